imem_loader: RTL
================

Name: imem_loader

Overview:
- Byte-stream program loader: the write-side counterpart of the read-only instruction memory.
- Receives a framed program image over a valid/ready byte interface and assembles 32-bit little-endian words.
- Writes each word into the instruction memory write port.
- Holds the processor core in reset until a complete image with a correct checksum has been stored.

Parameters:
- MIPS_SIZE, 32: data/address width of the instruction memory port.
- DEPTH_WORDS, 256: instruction memory capacity in words; maximum legal word count.
- SYNC_BYTE, 8'hA5: frame start marker.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  synchronous, active-high reset.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader can accept a byte; transfer occurs when in_valid && in_ready at a rising CLK edge.
- im_we  output  1  instruction memory write strobe, one cycle per word.
- im_addr  output  MIPS_SIZE  byte address of the word being written (word_index<<2).
- im_wdata  output  MIPS_SIZE  assembled instruction word.
- cpu_rst  output  1  reset to the core; high while loading or after an error.
- done  output  1  image loaded and checksum good; sticky until RST.
- error  output  1  frame error (oversize count or checksum mismatch); cleared on the next accepted SYNC_BYTE.
- words_loaded  output  16  count of words written in the current frame.

Behaviour:
- Clock and reset: one clock domain, CLK. Reset is synchronous and active-high on RST and is sampled only at a rising CLK edge.
- Values while RST is high and at reset exit:
  - state=IDLE, in_ready=0 during RST.
  - cpu_rst=1, done=0, error=0, im_we=0, im_addr=0, im_wdata=0, words_loaded=0.
  - Byte counter, checksum accumulator and word count all = 0.
- Frame format, in order:
  - SYNC_BYTE.
  - N_lo, N_hi: 16-bit word count N.
  - N×4 data bytes, each word least-significant byte first.
  - One checksum byte equal to the XOR of all data bytes.
- States:
  - IDLE: in_ready=1. Bytes other than SYNC_BYTE are accepted and discarded. SYNC_BYTE -> CNT_LO; clear checksum, byte counter and words_loaded.
  - CNT_LO: accept byte into N[7:0] -> CNT_HI.
  - CNT_HI: accept byte into N[15:8].
    - If N > DEPTH_WORDS -> ERR.
    - Else if N==0 -> CHK.
    - Else -> DATA.
  - DATA: each accepted byte is shifted into byte lane (byte counter mod 4) and XORed into the checksum.
    - On the 4th byte of a word, in the following cycle: im_we=1 for exactly one cycle, im_addr=words_loaded<<2, im_wdata=assembled word. words_loaded increments in the same cycle as the strobe.
    - After word N is written -> CHK.
  - CHK: accept one byte.
    - Equal to the accumulator -> DONE.
    - Else -> ERR.
  - DONE: in_ready=0, cpu_rst=0, done=1. Terminal until RST.
  - ERR: error=1, cpu_rst=1, in_ready=1. Non-sync bytes are discarded. SYNC_BYTE clears error and behaves as in IDLE (-> CNT_LO).
- Write-strobe timing: im_we latency is exactly 1 cycle after the 4th byte handshake. im_addr and im_wdata are held stable from that strobe until the next strobe.
- in_ready is high continuously in every state except DONE and reset, so back-to-back bytes on consecutive cycles are accepted with no bubbles, including across the final data byte -> checksum byte boundary.
- Stalls: in_valid low mid-word pauses assembly with no timeout. A partial word is never written.
- cpu_rst is registered and falls in the same cycle done rises, never earlier.
- RST mid-frame: returns to IDLE and discards the partial word. Already-written memory words are not erased, but cpu_rst=1 until a full good frame completes.
- N==DEPTH_WORDS is legal. The last write address is (DEPTH_WORDS-1)<<2.
- Counter widths: the byte counter is 2-bit and wraps 3->0 per word. words_loaded is 16-bit and never exceeds DEPTH_WORDS.

Test Plan:
- Reset, then the frame A5 02 00 | 13 00 00 20 | 05 00 01 20 | chk=0x17 -> im_we pulses at addr 0x0 (data 0x20000013) and addr 0x4 (data 0x20010005). Then done=1, cpu_rst 1->0, in_ready=0, words_loaded=2.
- Leading garbage 00 FF 3C followed by a valid N=1 frame -> garbage ignored, single write at addr 0, done=1.
- Valid N=1 frame with a checksum byte off by one -> no done, error=1, cpu_rst=1. A following good frame clears error and ends with done=1.
- N=DEPTH_WORDS+1 (0x0101 for default) -> ERR immediately after N_hi, im_we never asserted. N=0 with checksum 00 -> done=1 and zero writes.
- Random in_valid gaps inside a word, plus RST asserted after 2 data bytes -> no im_we for the partial word, outputs back at reset values, a subsequent full frame loads correctly.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: byte-stream program loader for the instruction memory.
//
// Accepts a framed program image over a valid/ready byte interface:
//   SYNC_BYTE, N_lo, N_hi, N*4 data bytes (LSB first per word), XOR checksum.
// Each completed word is written to the instruction memory write port, and
// the core is held in reset until a whole image with a good checksum is stored.
//
// Ports:
//   CLK, RST      - clock (rising edge), synchronous active-high reset
//   in_data       - stream byte
//   in_valid      - in_data valid
//   in_ready      - loader accepts a byte (transfer on in_valid && in_ready)
//   im_we         - instruction memory write strobe, one cycle per word
//   im_addr       - byte address of the word being written
//   im_wdata      - assembled instruction word
//   cpu_rst       - core reset, high while loading or after an error
//   done          - image loaded with good checksum, sticky until RST
//   error         - frame error, cleared by the next accepted SYNC_BYTE
//   words_loaded  - words written in the current frame
module imem_loader #(
    parameter int          MIPS_SIZE   = 32,
    parameter int          DEPTH_WORDS = 256,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [7:0]           in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 im_we,
    output logic [MIPS_SIZE-1:0] im_addr,
    output logic [MIPS_SIZE-1:0] im_wdata,
    output logic                 cpu_rst,
    output logic                 done,
    output logic                 error,
    output logic [15:0]          words_loaded
);

    localparam logic [15:0] DEPTH_N = 16'(DEPTH_WORDS);

    typedef enum logic [2:0] {
        IDLE, CNT_LO, CNT_HI, DATA, CHK, DONE, ERR
    } state_t;

    state_t      state, state_nxt;
    logic        xfer;
    logic        is_sync;
    logic [15:0] n_words;
    logic [15:0] n_hdr;
    logic [15:0] wl_inc;
    logic [1:0]  bcnt;
    logic [7:0]  csum;
    logic [23:0] lanes;

    assign xfer    = in_valid && in_ready;
    assign is_sync = (in_data == SYNC_BYTE);
    // Word count as it will be once the high byte currently on the bus lands.
    assign n_hdr   = {in_data, n_words[7:0]};
    assign wl_inc  = words_loaded + 16'd1;

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b1;
        cpu_rst   = 1'b1;
        done      = 1'b0;
        error     = 1'b0;
        case (state)
            IDLE: begin
                if (xfer && is_sync) state_nxt = CNT_LO;
            end
            CNT_LO: begin
                if (xfer) state_nxt = CNT_HI;
            end
            CNT_HI: begin
                if (xfer) begin
                    if (n_hdr > DEPTH_N)     state_nxt = ERR;
                    else if (n_hdr == 16'd0) state_nxt = CHK;
                    else                     state_nxt = DATA;
                end
            end
            DATA: begin
                // Leave on the last byte itself so the checksum byte can follow
                // with no bubble while the final write strobe is in flight.
                if (xfer && bcnt == 2'd3 && wl_inc == n_words) state_nxt = CHK;
            end
            CHK: begin
                if (xfer) state_nxt = (in_data == csum) ? DONE : ERR;
            end
            DONE: begin
                in_ready = 1'b0;
                cpu_rst  = 1'b0;
                done     = 1'b1;
            end
            ERR: begin
                error = 1'b1;
                if (xfer && is_sync) state_nxt = CNT_LO;
            end
            default: state_nxt = IDLE;
        endcase
        if (RST) in_ready = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= IDLE;
            bcnt         <= 2'd0;
            csum         <= 8'd0;
            n_words      <= 16'd0;
            lanes        <= 24'd0;
            words_loaded <= 16'd0;
            im_we        <= 1'b0;
            im_addr      <= '0;
            im_wdata     <= '0;
        end else begin
            state <= state_nxt;
            im_we <= 1'b0;
            if (xfer) begin
                case (state)
                    IDLE, ERR: begin
                        if (is_sync) begin
                            bcnt         <= 2'd0;
                            csum         <= 8'd0;
                            words_loaded <= 16'd0;
                        end
                    end
                    CNT_LO: n_words[7:0]  <= in_data;
                    CNT_HI: n_words[15:8] <= in_data;
                    DATA: begin
                        csum <= csum ^ in_data;
                        bcnt <= bcnt + 2'd1;
                        case (bcnt)
                            2'd0: lanes[7:0]   <= in_data;
                            2'd1: lanes[15:8]  <= in_data;
                            2'd2: lanes[23:16] <= in_data;
                            default: begin
                                im_we        <= 1'b1;
                                im_addr      <= MIPS_SIZE'({words_loaded, 2'b00});
                                im_wdata     <= MIPS_SIZE'({in_data, lanes});
                                words_loaded <= wl_inc;
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
